// File: rtl/ps2_lcd_sequencer_pkg.sv
// Shared scan-code constants, state types and scan-code to ASCII lookup
// for the PS/2 keyboard to lcd character path.
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {DEC_IDLE, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

   typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   // Set-2 make code to ASCII; 0 means "no printable character".
   function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
      logic [15:0] pair;  // {unshifted, shifted}
      pair = '0;
      if (!code[7]) begin
         case (code)
            8'h1C: pair = 16'h6141;  8'h32: pair = 16'h6242;
            8'h21: pair = 16'h6343;  8'h23: pair = 16'h6444;
            8'h24: pair = 16'h6545;  8'h2B: pair = 16'h6646;
            8'h34: pair = 16'h6747;  8'h33: pair = 16'h6848;
            8'h43: pair = 16'h6949;  8'h3B: pair = 16'h6A4A;
            8'h42: pair = 16'h6B4B;  8'h4B: pair = 16'h6C4C;
            8'h3A: pair = 16'h6D4D;  8'h31: pair = 16'h6E4E;
            8'h44: pair = 16'h6F4F;  8'h4D: pair = 16'h7050;
            8'h15: pair = 16'h7151;  8'h2D: pair = 16'h7252;
            8'h1B: pair = 16'h7353;  8'h2C: pair = 16'h7454;
            8'h3C: pair = 16'h7555;  8'h2A: pair = 16'h7656;
            8'h1D: pair = 16'h7757;  8'h22: pair = 16'h7858;
            8'h35: pair = 16'h7959;  8'h1A: pair = 16'h7A5A;
            8'h16: pair = 16'h3121;  8'h1E: pair = 16'h3240;
            8'h26: pair = 16'h3323;  8'h25: pair = 16'h3424;
            8'h2E: pair = 16'h3525;  8'h36: pair = 16'h365E;
            8'h3D: pair = 16'h3726;  8'h3E: pair = 16'h382A;
            8'h46: pair = 16'h3928;  8'h45: pair = 16'h3029;
            8'h29: pair = 16'h2020;  8'h5A: pair = 16'h0D0D;
            default: pair = '0;
         endcase
      end
      return shift ? pair[7:0] : pair[15:8];
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, PS2_CLK glitch filter,
// 11-bit frame FSM with odd parity, stop-bit and inter-edge timeout checks.
import ps2_pkg::*;

module ps2_frame_rx #(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1) + 1;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall, tmo;

   rx_state_t     state, state_n;
   logic [7:0]    shreg, shreg_n, byte_n;
   logic [2:0]    bcnt, bcnt_n;
   logic [TW-1:0] tmr, tmr_n;
   logic          par, par_n, vld_n, err_n;

   // Two-flop synchronisers; idle-high reset value avoids a false edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1; clk_s2 <= 1'b1; dat_s1 <= 1'b1; dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk; clk_s2 <= clk_s1;
         dat_s1 <= ps2_dat; dat_s2 <= dat_s1;
      end
   end

   // Accept a new PS2_CLK level only after FILT_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
         clk_filt <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign fall = clk_filt && !clk_s2 && (filt_cnt == FW'(FILT_LEN - 1));
   assign tmo  = (tmr >= TW'(TIMEOUT_CYC));

   // Receiver state and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RX_ARM;
         shreg     <= '0;
         bcnt      <= '0;
         tmr       <= '0;
         par       <= 1'b0;
         rx_byte   <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         bcnt      <= bcnt_n;
         tmr       <= tmr_n;
         par       <= par_n;
         rx_byte   <= byte_n;
         byte_vld  <= vld_n;
         frame_err <= err_n;
      end
   end

   // Frame sequencing: ARM waits for a long idle-high, then start/data/parity/stop.
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      bcnt_n  = bcnt;
      tmr_n   = tmr + TW'(1);
      par_n   = par;
      byte_n  = rx_byte;
      vld_n   = 1'b0;
      err_n   = 1'b0;
      case (state)
         RX_ARM: begin
            if (!clk_filt) begin
               tmr_n = '0;
            end else if (tmo) begin
               state_n = RX_IDLE;
               tmr_n   = '0;
            end
         end
         RX_IDLE: begin
            tmr_n = '0;
            if (fall && !dat_s2) begin
               state_n = RX_DATA;
               bcnt_n  = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shreg_n = {dat_s2, shreg[7:1]};
               bcnt_n  = bcnt + 3'd1;
               tmr_n   = '0;
               if (bcnt == 3'd7) state_n = RX_PAR;
            end
         end
         RX_PAR: begin
            if (fall) begin
               par_n   = dat_s2;
               tmr_n   = '0;
               state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               if (dat_s2 && (^{shreg, par})) begin
                  vld_n  = 1'b1;
                  byte_n = shreg;
               end else begin
                  err_n = 1'b1;
               end
               tmr_n   = '0;
               state_n = RX_IDLE;
            end
         end
         default: state_n = RX_ARM;
      endcase
      if ((state == RX_DATA || state == RX_PAR || state == RX_STOP) && !fall && tmo) begin
         err_n   = 1'b1;
         tmr_n   = '0;
         state_n = RX_ARM;
      end
   end

endmodule

// File: rtl/ps2_lcd_sequencer.sv
// PS/2 keyboard host: receives frames, decodes make/break/extended codes,
// tracks shift, converts to ASCII and queues characters for the lcd writer.
import ps2_pkg::*;

module ps2_lcd_sequencer #(
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   input  logic       lcd_ready,
   output logic [7:0] char_data,
   output logic       char_wr,
   output logic       shift_on,
   output logic       frame_err,
   output logic       overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [7:0]  rx_byte;
   logic        byte_vld;

   dec_state_t  dstate, dstate_n;
   logic        shift_n, push, push_n, is_shift;
   logic [7:0]  push_data, pdata_n, ascii;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, pop;

   ps2_frame_rx #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .ps2_clk   (PS2_CLK),
      .ps2_dat   (PS2_DAT),
      .rx_byte   (rx_byte),
      .byte_vld  (byte_vld),
      .frame_err (frame_err)
   );

   assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
   assign ascii    = ps2_to_ascii(rx_byte, shift_on);

   // Decoder state, shift flag and registered push request.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         dstate    <= DEC_IDLE;
         shift_on  <= 1'b0;
         push      <= 1'b0;
         push_data <= '0;
      end else begin
         dstate    <= dstate_n;
         shift_on  <= shift_n;
         push      <= push_n;
         push_data <= pdata_n;
      end
   end

   // Scan-code decoding; advances only on a received byte.
   always_comb begin
      dstate_n = dstate;
      shift_n  = shift_on;
      push_n   = 1'b0;
      pdata_n  = push_data;
      if (byte_vld) begin
         case (dstate)
            DEC_IDLE: begin
               if (rx_byte == SC_EXT)      dstate_n = DEC_EXT;
               else if (rx_byte == SC_BRK) dstate_n = DEC_BRK;
               else if (is_shift)          shift_n  = 1'b1;
               else if (ascii != '0) begin
                  push_n  = 1'b1;
                  pdata_n = ascii;
               end
            end
            DEC_BRK: begin
               if (is_shift) shift_n = 1'b0;
               dstate_n = DEC_IDLE;
            end
            DEC_EXT:     dstate_n = (rx_byte == SC_BRK) ? DEC_EXT_BRK : DEC_IDLE;
            DEC_EXT_BRK: dstate_n = DEC_IDLE;
            default:     dstate_n = DEC_IDLE;
         endcase
      end
   end

   assign char_wr   = (wr_ptr != rd_ptr);
   assign char_data = mem[rd_ptr[AW-1:0]];
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop       = char_wr && lcd_ready;

   // Character FIFO; a push into a full FIFO survives only if the head pops the same cycle.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         overflow <= push && full && !pop;
         if (push && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: tb/tb_ps2_lcd_sequencer.sv
// Directed bench: scan-code vector table plus hand sequences for
// parity/stop errors, FIFO overflow, timeout and reset mid-frame.
module tb_ps2_lcd_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       RESET    = 1'b1;
   logic       PS2_CLK  = 1'b1;
   logic       PS2_DAT  = 1'b1;
   logic       lcd_ready = 1'b1;
   logic [7:0] char_data;
   logic       char_wr, shift_on, frame_err, overflow;

   int checks = 0;
   int errors = 0;
   int n_ferr = 0, n_ovf = 0, n_wr = 0;
   logic [7:0] rxq[$];

   typedef struct {
      logic [7:0] code;
      logic [7:0] exp_ch;   // 0: no character expected
      logic       exp_shift;
   } vec_t;
   vec_t vecs[21];

   ps2_lcd_sequencer #(
      .FILT_LEN    (8),
      .TIMEOUT_CYC (300),
      .FIFO_DEPTH  (4)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET     (RESET),
      .PS2_CLK   (PS2_CLK),
      .PS2_DAT   (PS2_DAT),
      .lcd_ready (lcd_ready),
      .char_data (char_data),
      .char_wr   (char_wr),
      .shift_on  (shift_on),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Record transfers and pulses away from the active edge.
   always @(negedge CLOCK_50) begin
      if (!RESET) begin
         if (char_wr && lcd_ready) rxq.push_back(char_data);
         if (char_wr)   n_wr++;
         if (frame_err) n_ferr++;
         if (overflow)  n_ovf++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic par_flip,
                                            input logic stop);
      return {stop, (~^code) ^ par_flip, code, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = bits[i];
         wait_cyc(15);
         PS2_CLK = 1'b0;
         wait_cyc(30);
         PS2_CLK = 1'b1;
         wait_cyc(15);
      end
      PS2_DAT = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] code);
      send_bits(mk_frame(code, 1'b0, 1'b1), 11);
      wait_cyc(100);
   endtask

   initial begin
      int q0, w0, e0, o0;
      logic [10:0] fr;

      vecs[0]  = '{8'h1C, 8'h61, 1'b0};
      vecs[1]  = '{8'h12, 8'h00, 1'b1};
      vecs[2]  = '{8'h1C, 8'h41, 1'b1};
      vecs[3]  = '{8'hF0, 8'h00, 1'b1};
      vecs[4]  = '{8'h12, 8'h00, 1'b0};
      vecs[5]  = '{8'h1C, 8'h61, 1'b0};
      vecs[6]  = '{8'hE0, 8'h00, 1'b0};
      vecs[7]  = '{8'h75, 8'h00, 1'b0};
      vecs[8]  = '{8'hE0, 8'h00, 1'b0};
      vecs[9]  = '{8'hF0, 8'h00, 1'b0};
      vecs[10] = '{8'h75, 8'h00, 1'b0};
      vecs[11] = '{8'h1C, 8'h61, 1'b0};
      vecs[12] = '{8'h59, 8'h00, 1'b1};
      vecs[13] = '{8'h16, 8'h21, 1'b1};
      vecs[14] = '{8'hF0, 8'h00, 1'b1};
      vecs[15] = '{8'h59, 8'h00, 1'b0};
      vecs[16] = '{8'h16, 8'h31, 1'b0};
      vecs[17] = '{8'h01, 8'h00, 1'b0};
      vecs[18] = '{8'hE0, 8'h00, 1'b0};
      vecs[19] = '{8'h12, 8'h00, 1'b0};
      vecs[20] = '{8'h29, 8'h20, 1'b0};

      wait_cyc(5);
      chk("reset outputs", {char_data, char_wr, shift_on, frame_err, overflow}, '0);
      RESET = 1'b0;
      wait_cyc(1);
      chk("post-reset outputs", {char_data, char_wr, shift_on, frame_err, overflow}, '0);
      wait_cyc(400);

      for (int i = 0; i < 21; i++) begin
         q0 = rxq.size(); w0 = n_wr; e0 = n_ferr;
         send_byte(vecs[i].code);
         chk($sformatf("vec%0d count", i), rxq.size() - q0, (vecs[i].exp_ch != 0) ? 1 : 0);
         chk($sformatf("vec%0d wr_cycles", i), n_wr - w0, (vecs[i].exp_ch != 0) ? 1 : 0);
         if (vecs[i].exp_ch != 0 && rxq.size() > q0)
            chk($sformatf("vec%0d char", i), rxq[q0], vecs[i].exp_ch);
         chk($sformatf("vec%0d shift", i), shift_on, vecs[i].exp_shift);
         chk($sformatf("vec%0d frame_err", i), n_ferr - e0, 0);
      end

      // Bad parity, then a good frame.
      q0 = rxq.size(); e0 = n_ferr;
      send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
      wait_cyc(100);
      chk("badpar err", n_ferr - e0, 1);
      chk("badpar nochar", rxq.size() - q0, 0);
      send_byte(8'h32);
      chk("after badpar count", rxq.size() - q0, 1);
      if (rxq.size() > q0) chk("after badpar char", rxq[q0], 8'h62);

      // Bad stop bit.
      q0 = rxq.size(); e0 = n_ferr;
      send_bits(mk_frame(8'h21, 1'b0, 1'b0), 11);
      wait_cyc(100);
      chk("badstop err", n_ferr - e0, 1);
      chk("badstop nochar", rxq.size() - q0, 0);

      // Overflow with lcd held off, then drain in order.
      lcd_ready = 1'b0;
      q0 = rxq.size(); o0 = n_ovf;
      send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
      chk("ovf none yet", n_ovf - o0, 0);
      send_byte(8'h24);
      chk("ovf pulse", n_ovf - o0, 1);
      chk("ovf held char_wr", char_wr, 1'b1);
      chk("ovf held char_data", char_data, 8'h61);
      chk("ovf no transfer", rxq.size() - q0, 0);
      lcd_ready = 1'b1;
      wait_cyc(10);
      chk("drain count", rxq.size() - q0, 4);
      chk("drain empty", char_wr, 1'b0);
      if (rxq.size() - q0 == 4) begin
         chk("drain 0", rxq[q0],   8'h61);
         chk("drain 1", rxq[q0+1], 8'h62);
         chk("drain 2", rxq[q0+2], 8'h63);
         chk("drain 3", rxq[q0+3], 8'h64);
      end

      // Truncated frame, clock left high past the timeout.
      q0 = rxq.size(); e0 = n_ferr;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 4);
      wait_cyc(400);
      chk("timeout err", n_ferr - e0, 1);
      chk("timeout nochar", rxq.size() - q0, 0);
      wait_cyc(400);
      send_byte(8'h1C);
      chk("after timeout count", rxq.size() - q0, 1);
      if (rxq.size() > q0) chk("after timeout char", rxq[q0], 8'h61);

      // Reset in the middle of a frame; the rest of the frame must be ignored.
      q0 = rxq.size(); e0 = n_ferr; w0 = n_wr;
      fr = mk_frame(8'h1C, 1'b0, 1'b1);
      send_bits(fr, 4);
      RESET = 1'b1;
      wait_cyc(2);
      RESET = 1'b0;
      send_bits(fr >> 4, 7);
      wait_cyc(100);
      chk("midreset err", n_ferr - e0, 0);
      chk("midreset nochar", n_wr - w0, 0);
      wait_cyc(400);
      send_byte(8'h1C);
      chk("after midreset count", rxq.size() - q0, 1);
      if (rxq.size() > q0) chk("after midreset char", rxq[q0], 8'h61);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
